// File: rtl/serial_shift_engine.sv
// Shift register with manual per-edge operations and an automatic multi-bit shift FSM.
// Optional feature: define SERIAL_SHIFT_ROTATE_EN to add a rotate input (exiting bit re-enters).
module serial_shift_engine #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic [CNT_W-1:0] shift_len,
  input  logic             dir,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             serial_in,
  output logic [WIDTH-1:0] parallel_out,
  output logic             serial_out,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SHIFT_ROTATE_EN
  ,
  input  logic             rotate
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {M_HOLD, M_LEFT, M_RIGHT, M_PLOAD} mode_t;

  state_t           state;
  logic [WIDTH-1:0] mem;
  logic [CNT_W-1:0] cnt;
  logic             dir_q;
  logic             rot_idle;
  logic             rot_shift;

`ifdef SERIAL_SHIFT_ROTATE_EN
  logic rot_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rot_q <= 1'b0;
    end else if (state == IDLE && start) begin
      rot_q <= rotate;
    end
  end

  assign rot_idle  = rotate;
  assign rot_shift = rot_q;
`else
  assign rot_idle  = 1'b0;
  assign rot_shift = 1'b0;
`endif

  logic             eff_dir;
  logic             eff_rot;
  logic             ins_l;
  logic             ins_r;
  logic [WIDTH-1:0] shl;
  logic [WIDTH-1:0] shr;
  logic [CNT_W-1:0] cnt_load;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    eff_dir = dir;
    eff_rot = rot_idle;
    if (state == SHIFT) begin
      eff_dir = dir_q;
      eff_rot = rot_shift;
    end
    ins_l    = eff_rot ? mem[WIDTH-1] : serial_in;
    ins_r    = eff_rot ? mem[0]       : serial_in;
    shl      = {mem[WIDTH-2:0], ins_l};
    shr      = {ins_r, mem[WIDTH-1:1]};
    cnt_load = (shift_len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : shift_len;
  end

  assign parallel_out = mem;
  assign serial_out   = eff_dir ? mem[0] : mem[WIDTH-1];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mem   <= '0;
      cnt   <= '0;
      dir_q <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dir_q <= dir;
            cnt   <= cnt_load;
            if (shift_len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= SHIFT;
              busy  <= 1'b1;
            end
          end else begin
            case (mode_t'(mode))
              M_LEFT:  mem <= shl;
              M_RIGHT: mem <= shr;
              M_PLOAD: mem <= parallel_in;
              default: mem <= mem;
            endcase
          end
        end
        SHIFT: begin
          mem <= dir_q ? shr : shl;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_shift_engine.sv
// Directed bench for serial_shift_engine (WIDTH=8): vector table for manual modes,
// hand-written sequences for automatic shifts, saturation, reset abort and rotate.
module tb_serial_shift_engine;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] shift_len = '0;
  logic             dir = 1'b0;
  logic [WIDTH-1:0] parallel_in = '0;
  logic             serial_in = 1'b0;
  logic [WIDTH-1:0] parallel_out;
  logic             serial_out;
  logic             busy;
  logic             done;
  logic             rotate = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;

  serial_shift_engine #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mode         (mode),
    .start        (start),
    .shift_len    (shift_len),
    .dir          (dir),
    .parallel_in  (parallel_in),
    .serial_in    (serial_in),
    .parallel_out (parallel_out),
    .serial_out   (serial_out),
    .busy         (busy),
    .done         (done)
`ifdef SERIAL_SHIFT_ROTATE_EN
    ,
    .rotate       (rotate)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pload(input logic [WIDTH-1:0] v);
    mode = 2'd3;
    parallel_in = v;
    step();
    mode = 2'd0;
  endtask

  typedef struct {
    string            name;
    logic [1:0]       mode;
    logic             si;
    logic             dir;
    logic [WIDTH-1:0] pin;
    logic [WIDTH-1:0] exp_pout;
    logic             exp_so;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int cycles;
    int done_seen;
    logic exp_so_seq[3];

    vecs[0] = '{"pload_a5",   2'd3, 1'b0, 1'b0, 8'hA5, 8'hA5, 1'b1};
    vecs[1] = '{"left_si1",   2'd1, 1'b1, 1'b0, 8'h00, 8'h4B, 1'b0};
    vecs[2] = '{"right_si0",  2'd2, 1'b0, 1'b1, 8'h00, 8'h25, 1'b1};
    vecs[3] = '{"hold",       2'd0, 1'b1, 1'b0, 8'hFF, 8'h25, 1'b0};
    vecs[4] = '{"right_si1",  2'd2, 1'b1, 1'b1, 8'h00, 8'h92, 1'b0};
    vecs[5] = '{"left_si0",   2'd1, 1'b0, 1'b0, 8'h00, 8'h24, 1'b0};
    vecs[6] = '{"left_dir1",  2'd1, 1'b1, 1'b1, 8'h00, 8'h49, 1'b1};
    vecs[7] = '{"pload_7e",   2'd3, 1'b1, 1'b1, 8'h7E, 8'h7E, 1'b0};

    // Reset state
    #12;
    check("rst_pout", parallel_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    #5;

    // Manual modes in IDLE
    for (int i = 0; i < 8; i++) begin
      mode = vecs[i].mode;
      serial_in = vecs[i].si;
      dir = vecs[i].dir;
      parallel_in = vecs[i].pin;
      step();
      check({vecs[i].name, "_pout"}, parallel_out, vecs[i].exp_pout);
      check({vecs[i].name, "_so"}, serial_out, vecs[i].exp_so);
      check({vecs[i].name, "_busy"}, busy, 0);
    end
    mode = 2'd0;

    // Automatic right shift of 3 bits from 0x81 with serial_in=1
    pload(8'h81);
    exp_so_seq = '{1'b1, 1'b0, 1'b0};
    start = 1'b1; shift_len = CNT_W'(3); dir = 1'b1; serial_in = 1'b1;
    step();
    start = 1'b0; dir = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("auto3_busy%0d", i), busy, 1);
      check($sformatf("auto3_so%0d", i), serial_out, exp_so_seq[i]);
      check($sformatf("auto3_done%0d", i), done, 0);
      step();
    end
    check("auto3_pout", parallel_out, 8'hF0);
    check("auto3_done", done, 1);
    check("auto3_busy_end", busy, 0);
    step();
    check("auto3_done_clr", done, 0);

    // Zero-length shift
    pload(8'h3C);
    start = 1'b1; shift_len = '0;
    step();
    start = 1'b0;
    check("zero_busy", busy, 0);
    check("zero_done", done, 1);
    check("zero_pout", parallel_out, 8'h3C);
    step();
    check("zero_done_clr", done, 0);
    check("zero_pout2", parallel_out, 8'h3C);

    // Saturating length; start and PLOAD mid-run are ignored
    pload(8'hFF);
    start = 1'b1; shift_len = CNT_W'(15); dir = 1'b0; serial_in = 1'b0;
    step();
    start = 1'b0;
    cycles = 0;
    while (busy && cycles < 20) begin
      cycles++;
      if (cycles == 3) begin start = 1'b1; mode = 2'd3; parallel_in = 8'hAA; end
      if (cycles == 4) begin start = 1'b0; mode = 2'd0; end
      step();
    end
    check("sat_cycles", cycles, 8);
    check("sat_pout", parallel_out, 8'h00);
    check("sat_done", done, 1);
    step();
    check("sat_idle_pout", parallel_out, 8'h00);

    // Reset during the second cycle of a 5-bit shift
    pload(8'hF0);
    start = 1'b1; shift_len = CNT_W'(5); dir = 1'b1; serial_in = 1'b1;
    step();
    start = 1'b0;
    step();
    check("abort_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_pout", parallel_out, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    #3;
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done || busy) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    check("abort_pout_after", parallel_out, 0);

    // Rotate: manual then automatic left by 4 from 0x81
    pload(8'h81);
    rotate = 1'b1; serial_in = 1'b0; mode = 2'd1;
    for (int i = 0; i < 4; i++) step();
    mode = 2'd0;
`ifdef SERIAL_SHIFT_ROTATE_EN
    check("rot_manual", parallel_out, 8'h18);
`else
    check("rot_manual", parallel_out, 8'h10);
`endif
    pload(8'h81);
    start = 1'b1; shift_len = CNT_W'(4); dir = 1'b0;
    step();
    start = 1'b0; rotate = 1'b0;
    cycles = 0;
    while (!done && cycles < 10) begin
      cycles++;
      step();
    end
    check("rot_auto_cycles", cycles, 4);
`ifdef SERIAL_SHIFT_ROTATE_EN
    check("rot_auto", parallel_out, 8'h18);
`else
    check("rot_auto", parallel_out, 8'h10);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/serial_shift_engine.md
SERIAL_SHIFT_ENGINE -- requirements
Module: serial_shift_engine

Interface
REQ-001 Parameter WIDTH, default 8, sets the register width in bits; legal range is 2 to 64.
REQ-002 Localparam CNT_W = $clog2(WIDTH)+1 sets the shift-count width and is not overridable.
REQ-003 clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 mode  input  2  manual operation used only in IDLE: 0 HOLD, 1 LEFT, 2 RIGHT, 3 PLOAD.
REQ-006 start  input  1  requests an automatic multi-bit shift; sampled only in IDLE.
REQ-007 shift_len  input  CNT_W  number of bits for the automatic shift; captured with start.
REQ-008 dir  input  1  automatic shift direction (0 = left/MSB out, 1 = right/LSB out); captured with start.
REQ-009 parallel_in  input  WIDTH  load data for PLOAD.
REQ-010 serial_in  input  1  bit shifted into the vacated end.
REQ-011 parallel_out  output  WIDTH  current register contents.
REQ-012 serial_out  output  1  next exiting bit: memory[WIDTH-1] for left, memory[0] for right.
REQ-013 busy  output  1  high while the state is SHIFT.
REQ-014 done  output  1  one-cycle pulse marking completion of an automatic shift.

Function
REQ-015 FSM states: IDLE, SHIFT, DONE.
REQ-016 In IDLE without start, mode acts each edge: HOLD keeps the value, LEFT gives {mem[W-2:0],serial_in}, RIGHT gives {serial_in,mem[W-1:1]}, PLOAD loads parallel_in.
REQ-017 In IDLE, start=1 wins over mode: the register holds, dir is latched, the counter loads min(shift_len, WIDTH), and the state goes to SHIFT, or to DONE if shift_len=0.
REQ-018 In SHIFT, each edge shifts one bit in the latched direction and decrements the counter; when the counter is 1, the state goes to DONE on that edge.
REQ-019 DONE lasts exactly one cycle with done=1, then returns to IDLE; a start presented in DONE is ignored.
REQ-020 An automatic shift of L>0 bits produces exactly L shifts on consecutive edges, busy high for L cycles, and done in the following cycle.
REQ-021 mode, start, shift_len and dir are ignored while in SHIFT or DONE; the latched dir governs serial_out during SHIFT, and the dir input governs it otherwise.
REQ-022 A shift_len greater than WIDTH saturates to WIDTH, so the register is fully replaced by serial_in bits.
REQ-023 serial_out and parallel_out are combinational from the register and the effective direction, with no added latency.

Reset
REQ-024 While rst_n=0: memory=0, state=IDLE, counter=0, busy=0, done=0, latched dir=0.
REQ-025 Reset during SHIFT or DONE aborts immediately, and no done pulse is produced after release.
REQ-026 The first edge after rst_n rises is processed as IDLE.

Configuration
REQ-027 Macro SERIAL_SHIFT_ROTATE_EN, when defined, adds a port rotate (input, 1 bit) sampled like mode in IDLE and latched with start.
REQ-028 With the macro defined and rotate=1, LEFT/RIGHT shifts (manual and automatic) insert the exiting bit instead of serial_in.
REQ-029 Without the macro, the rotate port is absent and shifts always insert serial_in.

Verification
REQ-030 WIDTH=8, PLOAD 0xA5, then LEFT with serial_in=1 -> parallel_out=0x4B; then RIGHT with serial_in=0 -> 0x25.
REQ-031 Load 0x81, start with shift_len=3, dir=1, serial_in=1 -> busy for 3 cycles, serial_out sequence 1,0,0, parallel_out=0xF0, done one cycle after.
REQ-032 start with shift_len=0 -> done pulses on the next cycle, busy never rises, and the register is unchanged.
REQ-033 shift_len=15 with WIDTH=8, serial_in=0, register 0xFF -> exactly 8 shifts, result 0x00; start and mode=PLOAD toggled mid-run have no effect.
REQ-034 rst_n pulled low at the second shift cycle of a 5-bit shift -> outputs are 0 at once, with no done pulse after release.
REQ-035 With SERIAL_SHIFT_ROTATE_EN and rotate=1, 0x81 left-shifted 4 bits -> 0x18; without the macro, serial_in=0 gives 0x10.
